// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM encoding and DDRAM command helper for the LCD row streamer.
package lcd_pkg;
    typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT_RS, DONE} state_t;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};
    function automatic logic [7:0] ddram_cmd(input logic [1:0] row);
        return CMD_SET_DDRAM | ROW_BASE[row];
    endfunction
endpackage

// File: rtl/lcd_last_char_finder.sv
// lcd_last_char_finder: index of the last non-space character of a row, plus an all-blank flag.
module lcd_last_char_finder
    import lcd_pkg::*;
#(
    parameter int COLS = 20,
    parameter int IW = 5
) (
    input  logic [COLS*8-1:0] db_i,
    output logic [IW-1:0]     last_o,
    output logic              all_blank_o
);
    always_comb begin
        last_o = '0;
        all_blank_o = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (db_i[(COLS-1-i)*8 +: 8] != CHAR_SPACE) begin
                last_o = IW'(i);
                all_blank_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/lcd_row_streamer.sv
// lcd_row_streamer: captures one LCD row, sends the set-DDRAM command for it,
// then streams its characters one accepted byte at a time.
module lcd_row_streamer
    import lcd_pkg::*;
#(
    parameter int COLS = 20,
    parameter int ROWS = 4,
    parameter int TRIM_TRAILING = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Write,
    input  logic [1:0]        Row,
    input  logic [COLS*8-1:0] DB,
    input  logic              Lista,
    input  logic              LCD_RS,
    output logic              Escribir,
    output logic              Es_Comando,
    output logic [7:0]        Dato_E_LCD,
    output logic              Ocupado,
    output logic              Lista2,
    output logic              Error
);
    localparam int IW = COLS > 1 ? $clog2(COLS) : 1;

    state_t                 state_q;
    logic [COLS-1:0][7:0]   db_q;
    logic [IW-1:0]          idx_q, last_q, last_d;
    logic                   blank_q, blank_d;
    logic                   esc_q, cmd_q, busy_q, done_q, err_q;
    logic [7:0]             dato_q;

    if (TRIM_TRAILING != 0) begin : g_trim
        lcd_last_char_finder #(.COLS(COLS), .IW(IW)) u_find (
            .db_i       (DB),
            .last_o     (last_d),
            .all_blank_o(blank_d)
        );
    end else begin : g_full
        assign last_d  = IW'(COLS - 1);
        assign blank_d = 1'b0;
    end

    // char 0 sits in the top byte of DB, so character i lives at db_q[COLS-1-i]
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            db_q    <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            blank_q <= 1'b0;
            esc_q   <= 1'b0;
            cmd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dato_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (Write) begin
                    if (32'(Row) < ROWS) begin
                        state_q <= CMD;
                        db_q    <= DB;
                        last_q  <= last_d;
                        blank_q <= blank_d;
                        idx_q   <= '0;
                        esc_q   <= 1'b1;
                        cmd_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        dato_q  <= ddram_cmd(Row);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                CMD: if (Lista) begin
                    cmd_q   <= 1'b0;
                    state_q <= blank_q ? WAIT_RS : DATA;
                    esc_q   <= !blank_q;
                    dato_q  <= blank_q ? 8'h00 : db_q[IW'(COLS - 1)];
                end
                DATA: if (Lista) begin
                    if (idx_q == last_q) begin
                        state_q <= WAIT_RS;
                        esc_q   <= 1'b0;
                        dato_q  <= 8'h00;
                    end else begin
                        idx_q  <= idx_q + IW'(1);
                        dato_q <= db_q[IW'(COLS - 1) - (idx_q + IW'(1))];
                    end
                end
                WAIT_RS: if (!LCD_RS) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Escribir   = esc_q;
    assign Es_Comando = cmd_q;
    assign Dato_E_LCD = dato_q;
    assign Ocupado    = busy_q;
    assign Lista2     = done_q;
    assign Error      = err_q;
endmodule

// File: tb/tb_lcd_row_streamer.sv
// tb_lcd_row_streamer: table-driven and randomized checks of lcd_row_streamer in three
// configurations (full row, trailing-space trim, two-row panel).
module tb_lcd_row_streamer;
    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic [2:0]   wr = '0;
    logic [1:0]   Row = '0;
    logic [159:0] DB = '0;
    logic         Lista = 1'b0;
    logic         LCD_RS = 1'b1;
    logic [2:0]   esc, ecmd, busy, l2, err;
    logic [7:0]   dato [3];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   exp_q [$];
    logic [7:0]   base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    always #5 CLK = ~CLK;

    lcd_row_streamer #(.COLS(20), .ROWS(4), .TRIM_TRAILING(0)) u0 (
        .CLK(CLK), .Reset(Reset), .Write(wr[0]), .Row(Row), .DB(DB), .Lista(Lista), .LCD_RS(LCD_RS),
        .Escribir(esc[0]), .Es_Comando(ecmd[0]), .Dato_E_LCD(dato[0]), .Ocupado(busy[0]),
        .Lista2(l2[0]), .Error(err[0]));
    lcd_row_streamer #(.COLS(20), .ROWS(4), .TRIM_TRAILING(1)) u1 (
        .CLK(CLK), .Reset(Reset), .Write(wr[1]), .Row(Row), .DB(DB), .Lista(Lista), .LCD_RS(LCD_RS),
        .Escribir(esc[1]), .Es_Comando(ecmd[1]), .Dato_E_LCD(dato[1]), .Ocupado(busy[1]),
        .Lista2(l2[1]), .Error(err[1]));
    lcd_row_streamer #(.COLS(20), .ROWS(2), .TRIM_TRAILING(0)) u2 (
        .CLK(CLK), .Reset(Reset), .Write(wr[2]), .Row(Row), .DB(DB), .Lista(Lista), .LCD_RS(LCD_RS),
        .Escribir(esc[2]), .Es_Comando(ecmd[2]), .Dato_E_LCD(dato[2]), .Ocupado(busy[2]),
        .Lista2(l2[2]), .Error(err[2]));

    typedef struct {
        int         k;
        logic [1:0] row;
        string      txt;
        int         mode;
        int         rs_hold;
        logic [7:0] cmd;
        int         n;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] s2db(input string s);
        logic [159:0] d = '0;
        for (int i = 0; i < 20; i++) d[(19-i)*8 +: 8] = s[i];
        return d;
    endfunction

    // Expected byte stream: command, then the row text, optionally without trailing blanks.
    function automatic void model(input int k, input logic [1:0] row, input logic [159:0] d);
        logic [7:0] c [20];
        int n = 20;
        exp_q = {};
        exp_q.push_back(8'h80 | base[row]);
        for (int i = 0; i < 20; i++) c[i] = d[(19-i)*8 +: 8];
        if (k == 1) while (n > 0 && c[n-1] == " ") n--;
        for (int i = 0; i < n; i++) exp_q.push_back(c[i]);
    endfunction

    task automatic zero_chk(input string nm, input int k);
        chk(nm, {esc[k], ecmd[k], busy[k], l2[k], err[k], dato[k]}, 0);
    endtask

    task automatic xfer(input int k, input logic [1:0] row, input logic [159:0] d, input int mode,
                        input int rs_hold, input logic [7:0] exp_cmd, input int exp_n);
        logic [7:0] got [$];
        logic [7:0] held = '0;
        bit pend = 0, rs_fell = 0, done = 0, ok_rw = 0;
        int after = 0;
        model(k, row, d);
        @(posedge CLK) #1;
        wr[k] = 1'b1; Row = row; DB = d; LCD_RS = 1'b1;
        @(posedge CLK) #1;
        wr[k] = 1'b0; Row = 2'($urandom); DB = {5{$urandom}};
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            Lista = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom);
            if (got.size() == exp_q.size()) begin
                LCD_RS = after < rs_hold;
                if (!LCD_RS) rs_fell = 1;
                after++;
            end
            wr[k] = (cyc == 3) && ok_rw;
            if (wr[k]) Row = 2'($urandom);
            @(negedge CLK);
            if (cyc == 0) chk("latency", esc[k], 1);
            chk("no_error", err[k], 0);
            if (l2[k]) begin
                chk("lista2_after_rs", rs_fell, 1);
                chk("lista2_bytes", got.size(), exp_q.size());
                chk("busy_at_done", busy[k], 1);
                done = 1;
            end
            if (esc[k]) begin
                chk("cmd_flag", ecmd[k], got.size() == 0);
                if (pend) chk("hold", dato[k], held);
                pend = !Lista;
                held = dato[k];
                if (Lista) got.push_back(dato[k]);
            end else begin
                chk("idle_dato", dato[k], 0);
                pend = 0;
            end
            ok_rw = busy[k] && !l2[k];
            @(posedge CLK) #1;
        end
        wr[k] = 1'b0;
        chk("timeout", done, 1);
        @(negedge CLK);
        chk("lista2_one_cycle", l2[k], 0);
        chk("busy_clear", busy[k], 0);
        chk("n_bytes", got.size(), exp_q.size());
        chk("cmd_byte", got.size() > 0 ? 32'(got[0]) : 32'h100, exp_cmd);
        chk("n_data", got.size() - 1, exp_n);
        for (int i = 0; i < exp_q.size(); i++)
            chk("byte", i < got.size() ? 32'(got[i]) : 32'h100, exp_q[i]);
    endtask

    task automatic do_reset();
        @(posedge CLK) #1;
        Reset = 1'b1; wr = '0; Lista = 1'b0; LCD_RS = 1'b1;
        @(posedge CLK) #1;
        Reset = 1'b0;
    endtask

    initial begin
        vec_t tbl [7];
        int got_n;
        tbl[0] = '{0, 2'd1, "HELLO WORLD         ", 0, 0, 8'hC0, 20};
        tbl[1] = '{0, 2'd1, "HELLO WORLD         ", 1, 0, 8'hC0, 20};
        tbl[2] = '{1, 2'd3, "HELLO WORLD         ", 0, 0, 8'hD4, 11};
        tbl[3] = '{1, 2'd3, "                    ", 0, 0, 8'hD4, 0};
        tbl[4] = '{0, 2'd0, "HELLO WORLD         ", 0, 10, 8'h80, 20};
        tbl[5] = '{2, 2'd1, "ABCDEFGHIJKLMNOPQRST", 2, 2, 8'hC0, 20};
        tbl[6] = '{1, 2'd2, "  X                 ", 1, 1, 8'h94, 3};
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) zero_chk("reset_state", k);

        foreach (tbl[i]) begin
            do_reset();
            xfer(tbl[i].k, tbl[i].row, s2db(tbl[i].txt), tbl[i].mode, tbl[i].rs_hold, tbl[i].cmd, tbl[i].n);
        end

        // Out-of-range rows on the two-row panel are rejected with a single Error pulse.
        for (int r = 2; r < 4; r++) begin
            do_reset();
            wr[2] = 1'b1; Row = 2'(r); Lista = 1'b1; LCD_RS = 1'b0;
            @(posedge CLK) #1;
            wr[2] = 1'b0;
            @(negedge CLK);
            chk("error_pulse", err[2], 1);
            chk("error_no_esc", esc[2], 0);
            chk("error_not_busy", busy[2], 0);
            for (int c = 0; c < 5; c++) begin
                @(negedge CLK);
                chk("error_quiet", {err[2], esc[2], l2[2], busy[2]}, 0);
            end
        end

        // Reset after the fifth data byte aborts the transfer; a mid-transfer Write is ignored.
        do_reset();
        DB = s2db("ABCDEFGHIJKLMNOPQRST");
        model(0, 2'd2, DB);
        wr[0] = 1'b1; Row = 2'd2; Lista = 1'b1; LCD_RS = 1'b1;
        got_n = 0;
        for (int c = 0; c < 30 && got_n < 6; c++) begin
            @(posedge CLK) #1;
            wr[0] = (c == 2);
            Row = 2'd0;
            @(negedge CLK);
            if (esc[0]) begin
                chk("abort_prefix", dato[0], exp_q[got_n]);
                got_n++;
            end
        end
        chk("abort_reached", got_n, 6);
        @(posedge CLK) #1;
        Reset = 1'b1; wr[0] = 1'b0;
        @(posedge CLK) #1;
        Reset = 1'b0; LCD_RS = 1'b0;
        @(negedge CLK);
        zero_chk("abort_zero", 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("abort_no_lista2", {l2[0], esc[0]}, 0);
        end
        xfer(0, 2'd3, s2db("RESTART AFTER ABORT "), 0, 0, 8'hD4, 20);

        for (int it = 0; it < 10; it++) begin
            logic [159:0] d = '0;
            int k = $urandom_range(0, 1);
            int trail = $urandom_range(0, 20);
            logic [1:0] r = 2'($urandom);
            for (int i = 0; i < 20; i++) begin
                logic [7:0] ch = 8'("A" + $urandom_range(0, 25));
                if (i >= 20 - trail || (i != 19 - trail && $urandom_range(0, 3) == 0)) ch = " ";
                d[(19-i)*8 +: 8] = ch;
            end
            do_reset();
            xfer(k, r, d, 2, $urandom_range(0, 3), 8'h80 | base[r], k == 1 ? 20 - trail : 20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
